// File: rtl/mcp_pkg.sv
// Shared types and defaults for the multicycle-path receive block.
package mcp_pkg;

  localparam int unsigned MCP_WIDTH = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } mcp_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single-bit level crossing into clk.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
    end else begin
      s <= {s[STAGES-2:0], d};
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/brecv_mcp.sv
// Receive side of a toggle-handshake multicycle-path crossing: captures adata
// once per synchronized a_en transition and returns a toggle acknowledge.
module brecv_mcp
  import mcp_pkg::*;
#(
  parameter int unsigned WIDTH       = MCP_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             bclk,
  input  logic             brst_n,
  input  logic             a_en,
  input  logic [WIDTH-1:0] adata,
  input  logic             bload,
  output logic [WIDTH-1:0] bdata,
  output logic             bvalid,
  output logic             b_ack,
  output logic             berr
);

  mcp_state_e       state, state_d;
  logic [WIDTH-1:0] bdata_d;
  logic             b_ack_d;
  logic             berr_d;
  logic             s_sync;
  logic             s_prev;
  logic             bpulse;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (bclk),
    .rst_n(brst_n),
    .d    (a_en),
    .q    (s_sync)
  );

  // One-cycle strobe per request toggle; adata is stable by now, so it is
  // sampled directly without synchronization.
  assign bpulse = s_sync ^ s_prev;

  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      s_prev <= 1'b0;
      state  <= EMPTY;
      bdata  <= '0;
      b_ack  <= 1'b0;
      berr   <= 1'b0;
    end else begin
      s_prev <= s_sync;
      state  <= state_d;
      bdata  <= bdata_d;
      b_ack  <= b_ack_d;
      berr   <= berr_d;
    end
  end

  always_comb begin
    state_d = state;
    bdata_d = bdata;
    b_ack_d = b_ack;
    berr_d  = berr;
    case (state)
      EMPTY: begin
        if (bpulse) begin
          bdata_d = adata;
          state_d = FULL;
        end
      end
      FULL: begin
        // A request while still holding a word is dropped but flagged.
        if (bpulse) begin
          berr_d = 1'b1;
        end
        if (bload) begin
          b_ack_d = ~b_ack;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign bvalid = (state == FULL);

endmodule

// File: tb/tb_brecv_mcp.sv
// Scoreboard bench for brecv_mcp: directed protocol scenarios plus random transfers.
module tb_brecv_mcp;

  localparam int unsigned W = 8;

  logic         bclk   = 1'b0;
  logic         brst_n = 1'b0;
  logic         a_en   = 1'b0;
  logic         bload  = 1'b0;
  logic [W-1:0] adata  = '0;
  logic [W-1:0] bdata;
  logic         bvalid;
  logic         b_ack;
  logic         berr;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: words the receiver must present, in order, plus the
  // receiver's expected occupancy, ack parity and error flag.
  logic [W-1:0] exp_q[$];
  bit           model_full = 1'b0;
  logic         exp_ack    = 1'b0;
  logic         exp_berr   = 1'b0;
  logic         bvalid_q   = 1'b0;
  logic [W-1:0] mon_exp;

  brecv_mcp #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .bclk  (bclk),
    .brst_n(brst_n),
    .a_en  (a_en),
    .adata (adata),
    .bload (bload),
    .bdata (bdata),
    .bvalid(bvalid),
    .b_ack (b_ack),
    .berr  (berr)
  );

  always #5 bclk = ~bclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every newly presented word is popped from the scoreboard.
  always @(negedge bclk) begin
    if (brst_n && bvalid && !bvalid_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected none", bdata);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("capture_data", 32'(bdata), 32'(mon_exp));
      end
    end
    bvalid_q = bvalid;
  end

  // Toggle a_en just after an edge; the capture must follow three edges later.
  task automatic send(input logic [W-1:0] d);
    int lat;
    @(posedge bclk);
    #1;
    adata = d;
    a_en  = ~a_en;
    if (model_full) begin
      exp_berr = 1'b1;
    end else begin
      exp_q.push_back(d);
      lat = 0;
      while (!bvalid && lat < 12) begin
        @(posedge bclk);
        #1;
        lat++;
      end
      chk("latency", 32'(lat), 32'd3);
      model_full = 1'b1;
    end
  endtask

  task automatic load();
    @(posedge bclk);
    #1;
    bload = 1'b1;
    @(posedge bclk);
    #1;
    bload = 1'b0;
    if (model_full) begin
      exp_ack    = ~exp_ack;
      model_full = 1'b0;
    end
    chk("ack_toggle", 32'(b_ack), 32'(exp_ack));
    chk("bvalid_after_load", 32'(bvalid), 32'(model_full));
    chk("berr_sticky", 32'(berr), 32'(exp_berr));
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_full = 1'b0;
    exp_ack    = 1'b0;
    exp_berr   = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rd;
    #12;
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_bdata",  32'(bdata),  32'd0);
    chk("rst_b_ack",  32'(b_ack),  32'd0);
    chk("rst_berr",   32'(berr),   32'd0);
    @(posedge bclk);
    #1;
    brst_n = 1'b1;
    repeat (4) @(posedge bclk);
    #1;
    chk("release_no_pulse", 32'(bvalid), 32'd0);

    // Basic capture and acknowledge.
    send(8'hA5);
    chk("basic_data", 32'(bdata), 32'hA5);
    chk("basic_ack_idle", 32'(b_ack), 32'd0);
    load();
    chk("ack_data_retained", 32'(bdata), 32'hA5);

    // Back-to-back: next toggle one cycle after the ack.
    send(8'h3C);
    chk("b2b_data", 32'(bdata), 32'h3C);
    load();

    // Consumer stall keeps everything frozen.
    send(8'h5A);
    for (int i = 0; i < 20; i++) begin
      @(posedge bclk);
      #1;
      chk("stall_bvalid", 32'(bvalid), 32'd1);
      chk("stall_bdata",  32'(bdata),  32'h5A);
      chk("stall_b_ack",  32'(b_ack),  32'(exp_ack));
    end
    load();
    // bload in EMPTY must not move b_ack.
    load();

    // Protocol violation: extra toggle while FULL.
    send(8'h11);
    send(8'hFF);
    repeat (6) @(posedge bclk);
    #1;
    chk("viol_berr",   32'(berr),   32'd1);
    chk("viol_bdata",  32'(bdata),  32'h11);
    chk("viol_bvalid", 32'(bvalid), 32'd1);
    load();
    chk("viol_bdata_kept", 32'(bdata), 32'h11);

    // Randomized transfers with random stall and gap.
    for (int n = 0; n < 30; n++) begin
      rd = W'($urandom);
      send(rd);
      repeat ($urandom_range(0, 5)) @(posedge bclk);
      #1;
      chk("rand_data", 32'(bdata), 32'(rd));
      load();
      repeat ($urandom_range(0, 3)) @(posedge bclk);
    end

    // Asynchronous reset while FULL.
    send(8'hC3);
    @(posedge bclk);
    #2;
    brst_n = 1'b0;
    a_en   = 1'b0;
    bload  = 1'b0;
    model_reset();
    #1;
    chk("amid_bvalid", 32'(bvalid), 32'd0);
    chk("amid_bdata",  32'(bdata),  32'd0);
    chk("amid_b_ack",  32'(b_ack),  32'd0);
    chk("amid_berr",   32'(berr),   32'd0);
    repeat (3) @(posedge bclk);
    #1;
    brst_n = 1'b1;
    repeat (6) @(posedge bclk);
    #1;
    chk("post_rst_no_pulse", 32'(bvalid), 32'd0);
    chk("post_rst_berr",     32'(berr),   32'd0);

    send(8'h69);
    chk("post_rst_data", 32'(bdata), 32'h69);
    load();

    repeat (2) @(posedge bclk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
